apb_write_master: RTL
=====================

Name: apb_write_master

Overview:
- APB master sequencer directly upstream of the payload write slave; drives the slave's psel_x/penable/pwrite/pwdata/write_select bus.
- On one start request it latches payload_0, payload_1 and data_size and issues three APB write transfers, one per write_select index 0, 1, 2.
- Honours pready wait states, aborts on a wait-state timeout, and reports done/error to the local controller.

Parameters:
- DATA_W, 8, APB write data width
- SEL_W, 2, write_select width
- TIMEOUT, 16, max consecutive ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
- pclk  in  1  APB clock, rising edge
- preset_n  in  1  reset, asynchronous, active-low
- start  in  1  request pulse/level; sampled only in IDLE
- payload_0_in  in  DATA_W  value for write_select 0
- payload_1_in  in  DATA_W  value for write_select 1
- data_size_in  in  5  value for write_select 2, zero-extended onto pwdata
- busy  out  1  high from the cycle after start acceptance until the sequence ends
- done  out  1  one-cycle pulse: all three transfers completed
- error  out  1  one-cycle pulse: sequence aborted on timeout
- psel_x  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction, always 1 during transfers
- pwdata  out  DATA_W  APB write data
- write_select  out  SEL_W  target register index, 0..2
- pready  in  1  slave ready

Behaviour:
- Clock/reset: clock pclk; reset preset_n, asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; shadow registers, index and wait counter cleared.
- Reset mid-sequence: bus is dropped immediately (psel_x = penable = 0); done and error are not pulsed.
- Registered outputs: every output comes from flops; no combinational path from pready or start to any output.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - start = 1 at an edge latches the three inputs into shadow registers, sets index = 0 and moves to SETUP.
  - start while not in IDLE is ignored.
- SETUP (one cycle):
  - psel_x = 1, penable = 0, pwrite = 1.
  - write_select = index.
  - pwdata = shadow payload_0, payload_1 or {3'b0, data_size} for index 0, 1, 2 respectively.
  - Next state is ACCESS unconditionally.
- ACCESS:
  - psel_x = 1, penable = 1; pwdata, write_select and pwrite are held stable from SETUP.
  - pready = 1 completes the transfer at that edge.
  - On completion with index < 2: index increments and the FSM goes straight to SETUP. psel_x stays 1 and penable drops for one cycle; there is no IDLE gap.
  - On completion with index = 2: go to IDLE and pulse done for the next cycle.
- Timing:
  - Zero-wait sequence: start sampled at edge N; SETUP occupies cycles N+1, N+3, N+5 and ACCESS occupies N+2, N+4, N+6.
  - done = 1 in cycle N+7, with busy = 0 in the same cycle.
  - Each pready-low cycle in ACCESS extends that transfer by one cycle.
- Timeout (TIMEOUT > 0):
  - The wait counter counts consecutive ACCESS cycles with pready = 0 and clears on entry to each SETUP.
  - If pready is still low in the TIMEOUT-th consecutive ACCESS cycle, go to IDLE at that edge and pulse error in the next cycle. psel_x, penable, pwdata and write_select return to 0; done is not pulsed.
  - pready = 1 in that same cycle wins: the transfer completes normally.
  - Counter width is clog2(TIMEOUT+1).
- Idle bus: when not in SETUP or ACCESS, psel_x, penable, pwrite, pwdata and write_select are all 0.
- Back-to-back requests: start = 1 in the cycle where done = 1 (FSM already in IDLE) is accepted; the next SETUP follows one cycle later.
- Input changes: payload_*_in and data_size_in may change freely after acceptance; the bus uses only shadow values.
- Invariant: at most one of done and error is high in any cycle.

Test Plan:
- Reset, then start with payload_0_in=8'hA5, payload_1_in=8'h3C, data_size_in=5'd17, pready tied 1:
  - three transfers (sel 0/8'hA5, sel 1/8'h3C, sel 2/8'h11), SETUP/ACCESS alternating each cycle;
  - done exactly 7 cycles after the start edge; error stays 0.
- Same request with pready low for 3 cycles during the sel 1 ACCESS:
  - pwdata=8'h3C and write_select=1 held for 4 ACCESS cycles;
  - done at start+10.
- pready held low from the sel 0 ACCESS, TIMEOUT=16:
  - after 16 ACCESS cycles the bus drops to 0, error pulses for 1 cycle, done never asserts.
  - Repeat with pready rising exactly in cycle 16: transfer completes, sequence finishes with done.
- Inputs change to 8'hFF every cycle after acceptance:
  - bus still carries the values latched at acceptance.
  - start pulsed while busy: no effect on the sequence or the transfer count.
- Assert preset_n low during the sel 1 ACCESS:
  - all outputs 0 immediately (asynchronous), no done/error pulse;
  - after release, a new start issues sel 0 first.
- Start held high continuously:
  - sequences repeat back-to-back, each new SETUP one cycle after done, 3 transfers per done;
  - pwrite never 1 while psel_x is 0.

Source files
------------

// File: rtl/apb_write_master_if.sv
// APB write bus between the sequencer (master) and the payload write slave.
interface apb_write_master_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 2
);
  logic              psel_x;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [SEL_W-1:0]  write_select;
  logic              pready;

  modport master (
    output psel_x, penable, pwrite, pwdata, write_select,
    input  pready
  );

  modport slave (
    input  psel_x, penable, pwrite, pwdata, write_select,
    output pready
  );
endinterface

// File: rtl/apb_write_master.sv
// APB master that latches a three-word payload on start and writes it to
// write_select 0, 1, 2 with wait-state support and a wait-state timeout.
module apb_write_master #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] payload_0_in,
  input  logic [DATA_W-1:0] payload_1_in,
  input  logic [4:0]        data_size_in,
  output logic              busy,
  output logic              done,
  output logic              error,
  apb_write_master_if.master bus
);

  localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pay0_q, pay0_d, pay1_q, pay1_d;
  logic [4:0]        size_q, size_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  wait_q, wait_d;

  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [SEL_W-1:0]  wsel_q, wsel_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;

  // Next-state logic; bus outputs are decoded from the next state so they
  // appear registered in the cycle the FSM occupies that state.
  always_comb begin
    state_d   = state_q;
    pay0_d    = pay0_q;
    pay1_d    = pay1_q;
    size_d    = size_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pay0_d  = payload_0_in;
          pay1_d  = payload_1_in;
          size_d  = data_size_in;
          idx_d   = 2'd0;
          wait_d  = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.pready) begin
          if (idx_q == 2'd2) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 2'd1;
            wait_d  = '0;
            state_d = ST_SETUP;
          end
        end else if ((TIMEOUT != 0) && (wait_q == CNT_W'(TO_LAST))) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else if (TIMEOUT != 0) begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    psel_d    = (state_d != ST_IDLE);
    penable_d = (state_d == ST_ACCESS);
    pwrite_d  = psel_d;
    busy_d    = psel_d;
    wsel_d    = '0;
    pwdata_d  = '0;
    if (psel_d) begin
      wsel_d = SEL_W'(idx_d);
      unique case (idx_d)
        2'd0:    pwdata_d = pay0_d;
        2'd1:    pwdata_d = pay1_d;
        default: pwdata_d = DATA_W'(size_d);
      endcase
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= ST_IDLE;
      pay0_q    <= '0;
      pay1_q    <= '0;
      size_q    <= '0;
      idx_q     <= '0;
      wait_q    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      wsel_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pay0_q    <= pay0_d;
      pay1_q    <= pay1_d;
      size_q    <= size_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      wsel_q    <= wsel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign bus.psel_x       = psel_q;
  assign bus.penable      = penable_q;
  assign bus.pwrite       = pwrite_q;
  assign bus.pwdata       = pwdata_q;
  assign bus.write_select = wsel_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;

endmodule
